// File: rtl/pcie_dest_drain_if.sv
// Bundle of the drain's FIFO-side, sink-side and counter signals.
// Sink handshake: a word transfers on a rising edge where valid_out and ready_out are both high;
// while valid_out is high and ready_out is low, data_out and dest_out hold their values.
interface pcie_dest_drain_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
);
    logic              enable;
    logic              fifo_empty_d0;
    logic              fifo_empty_d1;
    logic [DATA_W-1:0] data_d0;
    logic [DATA_W-1:0] data_d1;
    logic              ready_out;
    logic              clr_cnt;
    logic              pop_d0;
    logic              pop_d1;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              dest_out;
    logic [CNT_W-1:0]  cnt_d0;
    logic [CNT_W-1:0]  cnt_d1;
    logic              drain_idle;

    modport master (
        input  enable, fifo_empty_d0, fifo_empty_d1, data_d0, data_d1, ready_out, clr_cnt,
        output pop_d0, pop_d1, data_out, valid_out, dest_out, cnt_d0, cnt_d1, drain_idle
    );

    modport slave (
        output enable, fifo_empty_d0, fifo_empty_d1, data_d0, data_d1, ready_out, clr_cnt,
        input  pop_d0, pop_d1, data_out, valid_out, dest_out, cnt_d0, cnt_d1, drain_idle
    );
endinterface

// File: rtl/pcie_dest_drain.sv
// Round-robin drain of the D0/D1 destination FIFOs into a valid/ready sink,
// one word in flight at a time, with per-destination delivered-word counters.
module pcie_dest_drain #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    pcie_dest_drain_if.master    bus,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        POP    = 2'd1,
        WAIT_D = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t            state_q;
    logic              pop_d0_q;
    logic              pop_d1_q;
    logic              valid_q;
    logic              dest_q;
    logic              grant_dest_q;
    logic              last_grant_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_d0_q;
    logic [CNT_W-1:0]  cnt_d1_q;
    logic [CNT_W-1:0]  cnt_d0_d;
    logic [CNT_W-1:0]  cnt_d1_d;
    logic              grant_d;
    logic              grant_dest_d;
    logic              accept_d;

    // A lone non-empty FIFO always wins; on a tie the one not granted last time wins.
    always_comb begin
        grant_d = bus.enable && !(bus.fifo_empty_d0 && bus.fifo_empty_d1);
        if (bus.fifo_empty_d0) begin
            grant_dest_d = 1'b1;
        end else if (bus.fifo_empty_d1) begin
            grant_dest_d = 1'b0;
        end else begin
            grant_dest_d = ~last_grant_q;
        end
        accept_d = (state_q == HOLD) && bus.ready_out;
        cnt_d0_d = cnt_d0_q;
        cnt_d1_d = cnt_d1_q;
        if (accept_d && !dest_q) cnt_d0_d = cnt_d0_q + 1'b1;
        if (accept_d &&  dest_q) cnt_d1_d = cnt_d1_q + 1'b1;
        // Clear takes priority over a same-edge increment.
        if (bus.clr_cnt) begin
            cnt_d0_d = '0;
            cnt_d1_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= ARB;
            pop_d0_q     <= 1'b0;
            pop_d1_q     <= 1'b0;
            valid_q      <= 1'b0;
            dest_q       <= 1'b0;
            grant_dest_q <= 1'b0;
            last_grant_q <= 1'b1;
            data_q       <= '0;
            cnt_d0_q     <= '0;
            cnt_d1_q     <= '0;
        end else begin
            cnt_d0_q <= cnt_d0_d;
            cnt_d1_q <= cnt_d1_d;
            case (state_q)
                ARB: begin
                    if (grant_d) begin
                        pop_d0_q     <= ~grant_dest_d;
                        pop_d1_q     <= grant_dest_d;
                        grant_dest_q <= grant_dest_d;
                        last_grant_q <= grant_dest_d;
                        state_q      <= POP;
                    end
                end
                POP: begin
                    pop_d0_q <= 1'b0;
                    pop_d1_q <= 1'b0;
                    state_q  <= WAIT_D;
                end
                // FIFO read data is valid the cycle after the pop strobe.
                WAIT_D: begin
                    data_q  <= grant_dest_q ? bus.data_d1 : bus.data_d0;
                    dest_q  <= grant_dest_q;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (bus.ready_out) begin
                        valid_q <= 1'b0;
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign bus.pop_d0     = pop_d0_q;
    assign bus.pop_d1     = pop_d1_q;
    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
    assign bus.dest_out   = dest_q;
    assign bus.cnt_d0     = cnt_d0_q;
    assign bus.cnt_d1     = cnt_d1_q;
    assign bus.drain_idle = (state_q == ARB) && bus.fifo_empty_d0 && bus.fifo_empty_d1;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pcie_dest_drain.sv
// Bench for pcie_dest_drain: FIFO models, round-robin reference order, negedge scoreboard monitor.
module tb_pcie_dest_drain;
  localparam int DW = 6;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [1:0] dbg_state;

  pcie_dest_drain_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  pcie_dest_drain #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0]    exp_q[$];    // {dest, data}
  logic [DW-1:0]  fq0[$];
  logic [DW-1:0]  fq1[$];
  logic [CW-1:0]  m_cnt0 = '0;
  logic [CW-1:0]  m_cnt1 = '0;
  logic           m_last = 1'b1;
  int             cyc = 0;
  int             pop_total = 0;
  int             pop_cyc_q[$];
  logic           pop_dest_q[$];
  bit             rand_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- FIFO models ----------------
  always @(posedge clk) begin
    cyc++;
    if (reset_L) begin
      if (bus.pop_d0) begin
        chk("no_underflow_d0", (fq0.size() != 0), 1);
        if (fq0.size() != 0) begin
          bus.data_d0 <= fq0.pop_front();
          bus.fifo_empty_d0 <= (fq0.size() == 0);
        end
      end
      if (bus.pop_d1) begin
        chk("no_underflow_d1", (fq1.size() != 0), 1);
        if (fq1.size() != 0) begin
          bus.data_d1 <= fq1.pop_front();
          bus.fifo_empty_d1 <= (fq1.size() == 0);
        end
      end
    end
  end

  // random sink/enable/clear behaviour, applied after the test-driven slot
  always @(posedge clk) begin
    #2;
    if (rand_mode) begin
      bus.ready_out = ($urandom_range(0, 2) != 0);
      bus.enable    = ($urandom_range(0, 3) != 0);
      bus.clr_cnt   = ($urandom_range(0, 29) == 0);
    end
  end

  // ---------------- monitor ----------------
  logic prev_valid, prev_hold, prev_acc, prev_pop, pend;
  logic [DW-1:0] hold_data;
  logic hold_dest;
  int last_pop_cyc;

  always @(negedge clk) begin
    logic [DW:0] e;
    logic busy;
    if (!reset_L) begin
      exp_q.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
      pend = 1'b0;
      prev_valid = 1'b0;
      prev_hold = 1'b0;
      prev_acc = 1'b0;
      prev_pop = 1'b0;
    end else begin
      chk("cnt_d0", bus.cnt_d0, m_cnt0);
      chk("cnt_d1", bus.cnt_d1, m_cnt1);
      busy = bus.pop_d0 || bus.pop_d1 || pend || bus.valid_out;
      chk("drain_idle", bus.drain_idle, !busy && bus.fifo_empty_d0 && bus.fifo_empty_d1);
      if (bus.pop_d0 || bus.pop_d1) begin
        pop_total++;
        pop_cyc_q.push_back(cyc);
        pop_dest_q.push_back(bus.pop_d1);
        chk("pop_onehot", bus.pop_d0 & bus.pop_d1, 0);
        chk("pop_one_cycle", prev_pop, 0);
        last_pop_cyc = cyc;
        pend = 1'b1;
      end
      if (bus.valid_out && !prev_valid) chk("pop_to_valid", cyc - last_pop_cyc, 2);
      if (prev_hold) begin
        chk("hold_valid", bus.valid_out, 1);
        chk("hold_data", bus.data_out, hold_data);
        chk("hold_dest", bus.dest_out, hold_dest);
      end
      if (prev_acc) chk("valid_drop", bus.valid_out, 0);
      if (bus.valid_out && bus.ready_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("word_dest", bus.dest_out, e[DW]);
          chk("word_data", bus.data_out, e[DW-1:0]);
        end
        if (bus.dest_out) m_cnt1 = m_cnt1 + 1'b1;
        else              m_cnt0 = m_cnt0 + 1'b1;
      end
      if (bus.clr_cnt) begin
        m_cnt0 = '0;
        m_cnt1 = '0;
      end
      if (bus.valid_out) pend = 1'b0;
      prev_pop   = bus.pop_d0 || bus.pop_d1;
      prev_valid = bus.valid_out;
      prev_hold  = bus.valid_out && !bus.ready_out;
      prev_acc   = bus.valid_out && bus.ready_out;
      hold_data  = bus.data_out;
      hold_dest  = bus.dest_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads both FIFOs at once and derives the delivery order from round-robin rules.
  task automatic load(input int n0, input int n1);
    logic [DW-1:0] a[$];
    logic [DW-1:0] b[$];
    logic [DW-1:0] w;
    logic pick;
    for (int i = 0; i < n0; i++) begin
      w = DW'($urandom_range(0, (1 << DW) - 1));
      a.push_back(w);
      fq0.push_back(w);
    end
    for (int i = 0; i < n1; i++) begin
      w = DW'($urandom_range(0, (1 << DW) - 1));
      b.push_back(w);
      fq1.push_back(w);
    end
    while (a.size() != 0 || b.size() != 0) begin
      if (a.size() != 0 && b.size() != 0) pick = ~m_last;
      else pick = (a.size() == 0);
      if (pick) exp_q.push_back({1'b1, b.pop_front()});
      else      exp_q.push_back({1'b0, a.pop_front()});
      m_last = pick;
    end
    if (n0 != 0) bus.fifo_empty_d0 = 1'b0;
    if (n1 != 0) bus.fifo_empty_d1 = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      tick();
      if (exp_q.size() == 0 && fq0.size() == 0 && fq1.size() == 0 && bus.drain_idle) break;
    end
    chk("drain_timeout", (k < max_cyc), 1);
  endtask

  task automatic wait_sig(input string name, input int which, input int max_cyc);
    int k;
    logic hit;
    hit = 1'b0;
    for (k = 0; k < max_cyc && !hit; k++) begin
      tick();
      hit = (which == 0) ? bus.pop_d0 : (which == 1) ? bus.pop_d1 : bus.valid_out;
    end
    chk(name, hit, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p0;
    logic [DW-1:0] w1, w2;
    logic [CW-1:0] c1;
    bus.enable = 1'b1;
    bus.fifo_empty_d0 = 1'b1;
    bus.fifo_empty_d1 = 1'b1;
    bus.data_d0 = '0;
    bus.data_d1 = '0;
    bus.ready_out = 1'b1;
    bus.clr_cnt = 1'b0;

    // 1: reset then idle with both FIFOs empty
    repeat (4) tick();
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_pops", {bus.pop_d0, bus.pop_d1}, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_dest", bus.dest_out, 0);
    chk("rst_cnts", {bus.cnt_d0, bus.cnt_d1}, 0);
    reset_L = 1'b1;
    repeat (20) tick();
    chk("idle_no_pop", pop_total, 0);
    chk("idle_flag", bus.drain_idle, 1);

    // 3: both FIFOs hold three words, first tie after reset goes to D0
    pop_cyc_q.delete();
    pop_dest_q.delete();
    load(3, 3);
    wait_drain(60);
    chk("rr_pop_count", pop_cyc_q.size(), 6);
    for (int i = 0; i < 6 && i < pop_cyc_q.size(); i++) begin
      chk("rr_pop_dest", pop_dest_q[i], i % 2);
      if (i > 0) chk("rr_pop_gap", pop_cyc_q[i] - pop_cyc_q[i-1], 4);
    end
    chk("rr_cnt_d0", bus.cnt_d0, 3);
    chk("rr_cnt_d1", bus.cnt_d1, 3);

    // 2: single D0 word 0x2A
    fq0.push_back(6'h2A);
    exp_q.push_back({1'b0, 6'h2A});
    m_last = 1'b0;
    bus.fifo_empty_d0 = 1'b0;
    wait_drain(20);
    chk("single_cnt_d0", bus.cnt_d0, 4);

    // 4: D1 word stalled by the sink for 10 cycles
    bus.ready_out = 1'b0;
    p0 = pop_total;
    load(0, 1);
    wait_sig("stall_valid_seen", 2, 10);
    repeat (10) tick();
    chk("stall_valid_held", bus.valid_out, 1);
    chk("stall_dest", bus.dest_out, 1);
    chk("stall_one_pop", pop_total - p0, 1);
    bus.ready_out = 1'b1;
    wait_drain(10);
    chk("stall_cnt_d1", bus.cnt_d1, 4);

    // 5: counter clear, wrap at 2^CNT_W, clear beating a same-edge increment
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt = 1'b0;
    load(255, 0);
    wait_drain(255 * 4 + 40);
    chk("cnt_255", bus.cnt_d0, 255);
    load(1, 0);
    wait_drain(20);
    chk("cnt_wrap", bus.cnt_d0, 0);
    load(1, 0);
    wait_drain(20);
    bus.ready_out = 1'b0;
    load(1, 0);
    wait_sig("clr_valid_seen", 2, 10);
    bus.ready_out = 1'b1;
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt = 1'b0;
    chk("clr_wins_d0", bus.cnt_d0, 0);
    chk("clr_accept_valid", bus.valid_out, 0);

    // randomized traffic against the round-robin reference order
    for (int r = 0; r < 12; r++) begin
      rand_mode = 1'b1;
      load($urandom_range(0, 5), $urandom_range(0, 5));
      wait_drain(400);
      rand_mode = 1'b0;
      bus.clr_cnt = 1'b0;
      bus.enable = 1'b1;
      bus.ready_out = 1'b1;
      tick();
    end

    // 6a: enable dropped while the pop is in progress
    w1 = DW'($urandom_range(0, 63));
    w2 = DW'($urandom_range(0, 63));
    fq0.push_back(w1);
    fq0.push_back(w2);
    exp_q.push_back({1'b0, w1});
    m_last = 1'b0;
    bus.fifo_empty_d0 = 1'b0;
    p0 = pop_total;
    wait_sig("en_pop_seen", 0, 10);
    bus.enable = 1'b0;
    repeat (20) tick();
    chk("en_word_done", exp_q.size(), 0);
    chk("en_no_more_pops", pop_total - p0, 1);
    chk("en_left_in_fifo", fq0.size(), 1);
    exp_q.push_back({1'b0, w2});
    bus.enable = 1'b1;
    wait_drain(20);

    // 6b: reset asserted while waiting for FIFO data
    c1 = bus.cnt_d0;
    chk("pre_rst_cnt_nonzero", (c1 != 0), 1);
    load(1, 0);
    wait_sig("rst_pop_seen", 0, 10);
    tick();
    reset_L = 1'b0;
    #1;
    chk("wrst_valid", bus.valid_out, 0);
    chk("wrst_pops", {bus.pop_d0, bus.pop_d1}, 0);
    chk("wrst_data", bus.data_out, 0);
    chk("wrst_cnts", {bus.cnt_d0, bus.cnt_d1}, 0);
    repeat (3) tick();
    reset_L = 1'b1;
    m_last = 1'b1;
    p0 = pop_total;
    repeat (5) tick();
    chk("wrst_no_pop", pop_total - p0, 0);
    chk("wrst_no_valid", bus.valid_out, 0);
    pop_dest_q.delete();
    load(1, 1);
    wait_drain(30);
    chk("wrst_tie_d0_first", (pop_dest_q.size() == 2) && (pop_dest_q[0] == 1'b0), 1);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
